// File: rtl/pong_pkg.sv
// Shared constants, encodings and small helpers for the pong datapath.
package pong_pkg;

  localparam int unsigned SCR_W    = 160;
  localparam int unsigned SCR_H    = 120;
  localparam int unsigned PAD_W    = 2;
  localparam int unsigned PAD_H    = 16;
  localparam int unsigned BALL_SZ  = 4;
  localparam int unsigned PAD_STEP = 2;
  localparam int unsigned LPAD_X   = 2;
  localparam int unsigned RPAD_X   = 156;

  localparam logic [2:0] BG_COL   = 3'b000;
  localparam logic [2:0] PAD_COL  = 3'b111;
  localparam logic [2:0] BALL_COL = 3'b010;

  localparam logic [6:0] PAD_Y_RST  = 7'd52;
  localparam logic [7:0] BALL_X_RST = 8'd78;
  localparam logic [6:0] BALL_Y_RST = 7'd58;

  localparam logic [6:0] PAD_Y_MAX  = 7'(SCR_H - PAD_H);
  localparam logic [6:0] BALL_Y_MAX = 7'(SCR_H - BALL_SZ);
  localparam logic [7:0] BALL_X_MAX = 8'(SCR_W - BALL_SZ);
  localparam logic [7:0] LBOUNCE_X  = 8'(LPAD_X + PAD_W);
  localparam logic [7:0] RBOUNCE_X  = 8'(RPAD_X - BALL_SZ);

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10
  } winner_e;

  typedef enum logic [1:0] {
    OBJ_CLEAR,
    OBJ_LPAD,
    OBJ_RPAD,
    OBJ_BALL
  } obj_e;

  function automatic logic [6:0] pad_next(logic [6:0] y, logic up, logic dn);
    logic [6:0] r;
    r = y;
    if (up && !dn)
      r = (y < 7'(PAD_STEP)) ? '0 : y - 7'(PAD_STEP);
    else if (dn && !up)
      r = (y >= PAD_Y_MAX - 7'(PAD_STEP)) ? PAD_Y_MAX : y + 7'(PAD_STEP);
    return r;
  endfunction

  function automatic logic ball_overlaps(logic [6:0] by, logic [6:0] pad_y);
    logic [7:0] b;
    logic [7:0] p;
    b = {1'b0, by};
    p = {1'b0, pad_y};
    return (b + 8'(BALL_SZ - 1) >= p) && (b <= p + 8'(PAD_H - 1));
  endfunction

endpackage

// File: rtl/pong_datapath_if.sv
// Strobe/key/pixel bundle between the pong control FSM and the datapath.
interface pong_datapath_if;
  logic       menu;
  logic       move_pads;
  logic       move_ball;
  logic       load_clear_screen;
  logic       load_left_pad;
  logic       load_right_pad;
  logic       load_ball;
  logic       clear_screen;
  logic       draw_left_pad;
  logic       draw_right_pad;
  logic       draw_ball;
  logic       reset_delta;
  logic       l_up;
  logic       l_down;
  logic       r_up;
  logic       r_down;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       gameover;
  logic [1:0] winner;

  modport master (
    output menu, move_pads, move_ball,
    output load_clear_screen, load_left_pad, load_right_pad, load_ball,
    output clear_screen, draw_left_pad, draw_right_pad, draw_ball,
    output reset_delta, l_up, l_down, r_up, r_down,
    input  x, y, colour, gameover, winner
  );

  modport slave (
    input  menu, move_pads, move_ball,
    input  load_clear_screen, load_left_pad, load_right_pad, load_ball,
    input  clear_screen, draw_left_pad, draw_right_pad, draw_ball,
    input  reset_delta, l_up, l_down, r_up, r_down,
    output x, y, colour, gameover, winner
  );
endinterface

// File: rtl/pong_rect_scanner.sv
// Raster scanner over a latched rectangle: x/y = base + (col,row), advanced per step.
module pong_rect_scanner (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       step_i,
  input  logic       clr_offset_i,
  input  logic [7:0] base_x_i,
  input  logic [6:0] base_y_i,
  input  logic [7:0] w_i,
  input  logic [6:0] h_i,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic       last_o
);
  import pong_pkg::*;

  logic [7:0] base_x_q, w_q, col_q, col_d;
  logic [6:0] base_y_q, h_q, row_q, row_d;
  logic       col_end;

  assign col_end = (col_q == w_q - 8'd1);
  assign last_o  = col_end && (row_q == h_q - 7'd1);
  assign x_o     = base_x_q + col_q;
  assign y_o     = base_y_q + row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (step_i && !last_o) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_q + 7'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_x_q <= '0;
      base_y_q <= '0;
      w_q      <= 8'(SCR_W);
      h_q      <= 7'(SCR_H);
      col_q    <= '0;
      row_q    <= '0;
    end else if (load_i) begin
      base_x_q <= base_x_i;
      base_y_q <= base_y_i;
      w_q      <= w_i;
      h_q      <= h_i;
      col_q    <= '0;
      row_q    <= '0;
    end else if (clr_offset_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/pong_datapath.sv
// Pong game state (paddles, ball, gameover/winner) and pixel generator for the VGA adapter.
module pong_datapath
  import pong_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  pong_datapath_if.slave bus
);

  logic [6:0] lpad_y_q, lpad_y_d, rpad_y_q, rpad_y_d;
  logic [7:0] bx_q, bx_d;
  logic [6:0] by_q, by_d;
  logic       dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic       gameover_q, gameover_d;
  winner_e    winner_q, winner_d;
  logic [2:0] colour_q;

  logic       clr, move_any, load_any, draw_any;
  logic       do_pads, do_ball, do_load, do_step;
  obj_e       obj;
  logic [7:0] ld_x, ld_w;
  logic [6:0] ld_y, ld_h;
  logic [2:0] ld_col;
  logic       scan_last;
  logic       frozen;

  assign clr      = reset || bus.menu;
  assign move_any = bus.move_pads || bus.move_ball;
  assign load_any = bus.load_clear_screen || bus.load_left_pad ||
                    bus.load_right_pad || bus.load_ball;
  assign draw_any = bus.clear_screen || bus.draw_left_pad ||
                    bus.draw_right_pad || bus.draw_ball;

  assign do_pads = !bus.menu && bus.move_pads;
  assign do_ball = !bus.menu && !bus.move_pads && bus.move_ball;
  assign do_load = !bus.menu && !move_any && load_any;
  assign do_step = !bus.menu && !move_any && !load_any && draw_any && !scan_last;

  assign lpad_y_d = pad_next(lpad_y_q, bus.l_up, bus.l_down);
  assign rpad_y_d = pad_next(rpad_y_q, bus.r_up, bus.r_down);

  // Only one x rule fires; a wall hit freezes both axes so the ball stays where it left.
  always_comb begin
    bx_d       = bx_q;
    by_d       = by_q;
    dx_neg_d   = dx_neg_q;
    dy_neg_d   = dy_neg_q;
    gameover_d = gameover_q;
    winner_d   = winner_q;
    frozen     = 1'b0;
    if (dx_neg_q && bx_q == LBOUNCE_X && ball_overlaps(by_q, lpad_y_q)) begin
      dx_neg_d = 1'b0;
      bx_d     = LBOUNCE_X + 8'd1;
    end else if (!dx_neg_q && bx_q == RBOUNCE_X && ball_overlaps(by_q, rpad_y_q)) begin
      dx_neg_d = 1'b1;
      bx_d     = RBOUNCE_X - 8'd1;
    end else if (dx_neg_q && bx_q == 8'd0) begin
      gameover_d = 1'b1;
      winner_d   = WIN_RIGHT;
      frozen     = 1'b1;
    end else if (!dx_neg_q && bx_q == BALL_X_MAX) begin
      gameover_d = 1'b1;
      winner_d   = WIN_LEFT;
      frozen     = 1'b1;
    end else begin
      bx_d = dx_neg_q ? bx_q - 8'd1 : bx_q + 8'd1;
    end

    if (!frozen) begin
      if (dy_neg_q) begin
        if (by_q == 7'd0) begin
          dy_neg_d = 1'b0;
          by_d     = 7'd1;
        end else begin
          by_d = by_q - 7'd1;
        end
      end else if (by_q == BALL_Y_MAX) begin
        dy_neg_d = 1'b1;
        by_d     = by_q - 7'd1;
      end else begin
        by_d = by_q + 7'd1;
      end
    end
  end

  always_comb begin
    obj = OBJ_CLEAR;
    if (bus.load_left_pad)       obj = OBJ_LPAD;
    else if (bus.load_right_pad) obj = OBJ_RPAD;
    else if (bus.load_ball)      obj = OBJ_BALL;
  end

  always_comb begin
    ld_x   = '0;
    ld_y   = '0;
    ld_w   = 8'(SCR_W);
    ld_h   = 7'(SCR_H);
    ld_col = BG_COL;
    case (obj)
      OBJ_LPAD: begin
        ld_x = 8'(LPAD_X);  ld_y = lpad_y_q;
        ld_w = 8'(PAD_W);   ld_h = 7'(PAD_H);   ld_col = PAD_COL;
      end
      OBJ_RPAD: begin
        ld_x = 8'(RPAD_X);  ld_y = rpad_y_q;
        ld_w = 8'(PAD_W);   ld_h = 7'(PAD_H);   ld_col = PAD_COL;
      end
      OBJ_BALL: begin
        ld_x = bx_q;        ld_y = by_q;
        ld_w = 8'(BALL_SZ); ld_h = 7'(BALL_SZ); ld_col = BALL_COL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      lpad_y_q   <= PAD_Y_RST;
      rpad_y_q   <= PAD_Y_RST;
      bx_q       <= BALL_X_RST;
      by_q       <= BALL_Y_RST;
      dx_neg_q   <= 1'b0;
      dy_neg_q   <= 1'b0;
      gameover_q <= 1'b0;
      winner_q   <= WIN_NONE;
      colour_q   <= BG_COL;
    end else if (do_pads) begin
      lpad_y_q <= lpad_y_d;
      rpad_y_q <= rpad_y_d;
    end else if (do_ball) begin
      bx_q       <= bx_d;
      by_q       <= by_d;
      dx_neg_q   <= dx_neg_d;
      dy_neg_q   <= dy_neg_d;
      gameover_q <= gameover_d;
      winner_q   <= winner_d;
    end else if (do_load) begin
      colour_q <= ld_col;
    end
  end

  pong_rect_scanner u_scan (
    .clk          (clk),
    .rst          (clr),
    .load_i       (do_load),
    .step_i       (do_step),
    .clr_offset_i (bus.reset_delta),
    .base_x_i     (ld_x),
    .base_y_i     (ld_y),
    .w_i          (ld_w),
    .h_i          (ld_h),
    .x_o          (bus.x),
    .y_o          (bus.y),
    .last_o       (scan_last)
  );

  assign bus.colour   = colour_q;
  assign bus.gameover = gameover_q;
  assign bus.winner   = winner_q;

endmodule
